// File: rtl/speaker_ctl_if.sv
`default_nettype none
// ============================================================================
// Module      : speaker_ctl_if
// Description : Sample-in / I2S-out bundle between note generator, serializer
//               and the audio Pmod DAC.
// Revision    : 1.0 - initial release
// ============================================================================
interface speaker_ctl_if;
    logic [15:0] audio_left;
    logic [15:0] audio_right;
    logic        audio_mclk;
    logic        audio_lrck;
    logic        audio_sck;
    logic        audio_sdin;
    logic        frame_start;

    modport master (
        input  audio_left, audio_right,
        output audio_mclk, audio_lrck, audio_sck, audio_sdin, frame_start
    );

    modport slave (
        output audio_left, audio_right,
        input  audio_mclk, audio_lrck, audio_sck, audio_sdin, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/speaker_ctl.sv
`default_nettype none
// ============================================================================
// Module      : speaker_ctl
// Description : Stereo 16-bit I2S serializer with DAC master/bit/word clocks
//               derived from a single free-running frame counter.
// Revision    : 1.0 - initial release
// ============================================================================
module speaker_ctl (
    input  wire logic            clk,
    input  wire logic            rst_n,
    speaker_ctl_if.master        bus
);

    logic [9:0]  r_cnt;
    logic [31:0] r_frame;
    logic        r_sdin;
    logic        r_frame_start;

    logic        w_frame_end;
    logic        w_slot_end;
    logic [4:0]  w_next_slot;
    logic [4:0]  w_bit_idx;

    assign w_frame_end = (r_cnt == 10'd1023);
    assign w_slot_end  = (r_cnt[4:0] == 5'd31);
    assign w_next_slot = r_cnt[9:5] + 5'd1;
    // 32 - s modulo 32: slot 0 maps to bit 0 (previous right LSB), slot s to bit 32-s
    assign w_bit_idx   = 5'd0 - w_next_slot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt         <= 10'd0;
            r_frame       <= 32'd0;
            r_sdin        <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_cnt         <= r_cnt + 10'd1;
            r_frame_start <= w_frame_end;
            if (w_frame_end) begin
                r_frame <= {bus.audio_left, bus.audio_right};
            end
            if (w_slot_end) begin
                r_sdin <= r_frame[w_bit_idx];
            end
        end
    end

    assign bus.audio_mclk  = r_cnt[1];
    assign bus.audio_sck   = r_cnt[4];
    assign bus.audio_lrck  = r_cnt[9];
    assign bus.audio_sdin  = r_sdin;
    assign bus.frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_speaker_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_speaker_ctl
// Description : Directed vector table plus reset, mid-frame and loopback
//               sequences for the I2S serializer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_speaker_ctl;

    logic clk;
    logic rst_n;

    speaker_ctl_if bus ();

    speaker_ctl u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic [31:0] exp_word;
        logic        exp_next0;
    } vec_t;

    vec_t        vecs[6];
    int          n_total;
    int          n_pass;
    logic [31:0] slots;
    logic [15:0] pl[10];
    logic [15:0] pr[10];
    logic [31:0] fr[9];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %h required %h", name, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Runs one full frame starting at a frame_start negedge; samples sdin at each sck rise
    task automatic collect_frame(input bit do_mid, output logic [31:0] s);
        s = '0;
        for (int k = 0; k < 1024; k++) begin
            if (k % 32 == 16) s[k / 32] = bus.audio_sdin;
            if (do_mid && k == 300) begin
                bus.audio_left  = 16'hFFFF;
                bus.audio_right = 16'hFFFF;
            end
            @(negedge clk);
        end
    endtask

    function automatic logic [31:0] slots_hi(input logic [31:0] s);
        logic [31:0] w;
        w = '0;
        for (int i = 1; i < 32; i++) w[32 - i] = s[i];
        return w;
    endfunction

    // Called at a negedge right after rst_n release; ends on the first frame_start
    task automatic clock_check(input string tag);
        int bad_m, bad_s, bad_l, lr_hi, fs_early, sd_hi;
        logic [31:0] c;
        bad_m = 0; bad_s = 0; bad_l = 0; lr_hi = 0; fs_early = 0; sd_hi = 0;
        for (int j = 1; j <= 1024; j++) begin
            @(negedge clk);
            c = j % 1024;
            if (bus.audio_mclk !== c[1]) bad_m++;
            if (bus.audio_sck  !== c[4]) bad_s++;
            if (bus.audio_lrck !== c[9]) bad_l++;
            if (bus.audio_lrck === 1'b1) lr_hi++;
            if (j < 1024 && bus.frame_start !== 1'b0) fs_early++;
            if (bus.audio_sdin !== 1'b0) sd_hi++;
        end
        chk({tag, "_mclk_wave"},   bad_m,    0);
        chk({tag, "_sck_wave"},    bad_s,    0);
        chk({tag, "_lrck_wave"},   bad_l,    0);
        chk({tag, "_lrck_high"},   lr_hi,    512);
        chk({tag, "_fs_early"},    fs_early, 0);
        chk({tag, "_fs_first"},    {31'd0, bus.frame_start}, 32'd1);
        chk({tag, "_frame0_zero"}, sd_hi,    0);
    endtask

    initial begin
        int bad;
        logic [15:0] dl, dr;
        n_total = 0;
        n_pass  = 0;

        vecs[0] = '{16'hB000, 16'h5FFF, 32'hB000_5FFF, 1'b1};
        vecs[1] = '{16'h8001, 16'h0000, 32'h8001_0000, 1'b0};
        vecs[2] = '{16'hFFFF, 16'hFFFF, 32'hFFFF_FFFF, 1'b1};
        vecs[3] = '{16'h0000, 16'h0001, 32'h0000_0001, 1'b1};
        vecs[4] = '{16'h1234, 16'hABCD, 32'h1234_ABCD, 1'b1};
        vecs[5] = '{16'hA5A5, 16'h5A5A, 32'hA5A5_5A5A, 1'b0};

        rst_n           = 1'b0;
        bus.audio_left  = 16'h0000;
        bus.audio_right = 16'h0000;

        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if ({bus.audio_mclk, bus.audio_lrck, bus.audio_sck, bus.audio_sdin, bus.frame_start} !== 5'b0)
                bad++;
        end
        chk("reset_outputs", bad, 0);
        rst_n = 1'b1;
        clock_check("por");

        // Table: each frame carries the vector captured at its frame_start
        bus.audio_left  = vecs[0].l;
        bus.audio_right = vecs[0].r;
        collect_frame(1'b0, slots);
        for (int i = 0; i < 6; i++) begin
            bus.audio_left  = (i < 5) ? vecs[i + 1].l : 16'h0000;
            bus.audio_right = (i < 5) ? vecs[i + 1].r : 16'h0000;
            collect_frame(1'b0, slots);
            chk("vec_slots1_31", slots_hi(slots) & 32'hFFFF_FFFE, vecs[i].exp_word & 32'hFFFF_FFFE);
            if (i > 0) chk("vec_slot0", {31'd0, slots[0]}, {31'd0, vecs[i - 1].exp_next0});
        end

        // Mid-frame input change is ignored until the next frame boundary
        collect_frame(1'b1, slots);
        chk("last_vec_slot0", {31'd0, slots[0]}, {31'd0, vecs[5].exp_next0});
        chk("mid_cur_zero", slots_hi(slots) & 32'hFFFF_FFFE, 32'h0);
        collect_frame(1'b0, slots);
        chk("mid_next_ones", slots_hi(slots) & 32'hFFFF_FFFE, 32'hFFFF_FFFE);
        chk("mid_next_slot0", {31'd0, slots[0]}, 32'd0);

        // Asynchronous reset between edges at cnt = 700 (sck and lrck high there)
        repeat (700) @(negedge clk);
        chk("pre_rst_sck_lrck", {30'd0, bus.audio_sck, bus.audio_lrck}, 32'd3);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_outputs",
               {27'd0, bus.audio_mclk, bus.audio_lrck, bus.audio_sck, bus.audio_sdin, bus.frame_start}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        clock_check("arst");

        // Loopback through a bench I2S receiver
        for (int i = 0; i < 10; i++) begin
            pl[i] = 16'($urandom);
            pr[i] = 16'($urandom);
        end
        bus.audio_left  = pl[0];
        bus.audio_right = pr[0];
        collect_frame(1'b0, slots);
        for (int f = 0; f < 9; f++) begin
            bus.audio_left  = pl[f + 1];
            bus.audio_right = pr[f + 1];
            collect_frame(1'b0, fr[f]);
        end
        for (int f = 0; f < 8; f++) begin
            for (int b = 0; b < 16; b++) dl[15 - b] = fr[f][1 + b];
            for (int b = 0; b < 15; b++) dr[15 - b] = fr[f][17 + b];
            dr[0] = fr[f + 1][0];
            chk("loopback_pair", {dl, dr}, {pl[f], pr[f]});
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
